// File: rtl/my_params_pkg.sv
// -----------------------------------------------------------------------------
// my_params_pkg
// Shared parameters and types for the burst memory block.
//   DWIDTH   : default data word width in bits (a multiple of 8)
//   AWIDTH   : default word address width (depth = 2**AWIDTH)
//   state_e  : burst controller FSM states
//   even_parity() : even-parity bit for one byte
// -----------------------------------------------------------------------------
package my_params_pkg;

   localparam int DWIDTH = 32;
   localparam int AWIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // The stored bit makes byte + bit carry an even number of ones.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// mem_rd_pipe
// Read-latency delay line for the burst memory. The valid/last strobes enter
// in the cycle the array read is issued. The data/parity-error pair enters one
// cycle later, straight off the array's registered read port. Both paths leave
// together exactly RD_LAT cycles after issue.
//   clk_i, rst_i     : clock, asynchronous active-high reset (flushes strobes)
//   issue_valid_i    : an array read is issued this cycle
//   issue_last_i     : the issued read is the final word of its burst
//   mem_data_i       : registered array read data (one cycle after issue)
//   mem_perr_i       : parity mismatch for mem_data_i
//   rd_data_o        : read word, forced to zero while rd_valid_o is low
//   rd_valid_o       : read word valid
//   rd_last_o        : final word of the burst (qualified by rd_valid_o)
//   rd_perr_o        : parity error on this word (qualified by rd_valid_o)
//   busy_o           : at least one read is still in flight
// -----------------------------------------------------------------------------
module mem_rd_pipe #(
   parameter int DWIDTH = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              issue_valid_i,
   input  logic              issue_last_i,
   input  logic [DWIDTH-1:0] mem_data_i,
   input  logic              mem_perr_i,
   output logic [DWIDTH-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic              rd_last_o,
   output logic              rd_perr_o,
   output logic              busy_o
);

   // Strobe chain: element 0 is the issue strobe, element RD_LAT the output.
   logic [RD_LAT:0] valid_chain;
   logic [RD_LAT:0] last_chain;

   // Data chain: element 0 is the array output (already one cycle late),
   // so only RD_LAT-1 further stages are needed.
   logic [DWIDTH-1:0] data_chain [RD_LAT];
   logic              perr_chain [RD_LAT];

   assign valid_chain[0] = issue_valid_i;
   assign last_chain[0]  = issue_last_i;
   assign data_chain[0]  = mem_data_i;
   assign perr_chain[0]  = mem_perr_i;

   for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_strobe
      logic valid_reg;
      logic last_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
         end else begin
            valid_reg <= valid_chain[gi];
            last_reg  <= last_chain[gi];
         end
      end

      assign valid_chain[gi+1] = valid_reg;
      assign last_chain[gi+1]  = last_reg;
   end

   for (genvar gi = 0; gi < RD_LAT - 1; gi++) begin : g_data
      logic [DWIDTH-1:0] data_reg;
      logic              perr_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            data_reg <= '0;
            perr_reg <= 1'b0;
         end else begin
            data_reg <= data_chain[gi];
            perr_reg <= perr_chain[gi];
         end
      end

      assign data_chain[gi+1] = data_reg;
      assign perr_chain[gi+1] = perr_reg;
   end

   assign rd_valid_o = valid_chain[RD_LAT];
   assign rd_last_o  = valid_chain[RD_LAT] & last_chain[RD_LAT];
   assign rd_perr_o  = valid_chain[RD_LAT] & perr_chain[RD_LAT-1];
   assign rd_data_o  = valid_chain[RD_LAT] ? data_chain[RD_LAT-1] : '0;
   assign busy_o     = |valid_chain[RD_LAT:1];

endmodule

// File: rtl/burst_mem.sv
// -----------------------------------------------------------------------------
// burst_mem
// Single-port word memory with a burst command interface. A command selects a
// write or read burst of cmd_len_i+1 words starting at cmd_addr_i. Addresses
// wrap modulo the depth. Write words are taken on a valid/ready handshake with
// per-byte enables. Read words stream out with no back-pressure, RD_LAT cycles
// after each array read.
//
// Optional feature: define BURST_MEM_PARITY_EN to store one even-parity bit per
// byte. Parity is checked on every read word, and rd_perr_o flags a mismatch.
// Without the macro there is no parity storage, and rd_perr_o is tied low.
//
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o: command handshake (ready only when idle)
//   cmd_wr_i               : 1 = write burst, 0 = read burst
//   cmd_addr_i             : burst start word address
//   cmd_len_i              : burst length minus one
//   wr_valid_i/wr_ready_o  : write data handshake (ready only in a write burst)
//   wr_data_i, wr_be_i     : write word and byte enables
//   rd_data_o              : read word, zero while rd_valid_o is low
//   rd_valid_o, rd_last_o  : read word valid, final word of the burst
//   busy_o                 : burst in progress or reads still in flight
//   rd_perr_o              : parity error on the current read word
// -----------------------------------------------------------------------------
module burst_mem #(
   parameter int DWIDTH = my_params_pkg::DWIDTH,
   parameter int AWIDTH = my_params_pkg::AWIDTH,
   parameter int RD_LAT = 1,
   parameter int LWIDTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_wr_i,
   input  logic [AWIDTH-1:0]   cmd_addr_i,
   input  logic [LWIDTH-1:0]   cmd_len_i,
   input  logic                wr_valid_i,
   output logic                wr_ready_o,
   input  logic [DWIDTH-1:0]   wr_data_i,
   input  logic [DWIDTH/8-1:0] wr_be_i,
   output logic [DWIDTH-1:0]   rd_data_o,
   output logic                rd_valid_o,
   output logic                rd_last_o,
   output logic                busy_o,
   output logic                rd_perr_o
);

   import my_params_pkg::*;

   localparam int NBYTES = DWIDTH / 8;
   localparam int DEPTH  = 2 ** AWIDTH;
   localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
   localparam logic [LWIDTH-1:0] CNT_ONE  = LWIDTH'(1);

   state_e            state_reg, state_next;
   logic [AWIDTH-1:0] addr_reg,  addr_next;
   logic [LWIDTH-1:0] cnt_reg,   cnt_next;   // words remaining after current

   logic              wr_en;
   logic              rd_issue;
   logic              rd_issue_last;
   logic [DWIDTH-1:0] mem_rd_data;
   logic [NBYTES-1:0] lane_perr;
   logic              pipe_busy;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      cnt_next      = cnt_reg;
      cmd_ready_o   = 1'b0;
      wr_ready_o    = 1'b0;
      wr_en         = 1'b0;
      rd_issue      = 1'b0;
      rd_issue_last = 1'b0;

      unique case (state_reg)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               addr_next  = cmd_addr_i;
               cnt_next   = cmd_len_i;
               state_next = cmd_wr_i ? ST_WRITE : ST_READ;
            end
         end

         ST_WRITE: begin
            wr_ready_o = 1'b1;
            if (wr_valid_i) begin
               wr_en     = 1'b1;
               addr_next = addr_reg + ADDR_ONE;
               cnt_next  = cnt_reg - CNT_ONE;
               if (cnt_reg == '0) begin
                  state_next = ST_IDLE;
               end
            end
         end

         ST_READ: begin
            // One array read per cycle; the consumer cannot stall us.
            rd_issue      = 1'b1;
            rd_issue_last = (cnt_reg == '0);
            addr_next     = addr_reg + ADDR_ONE;
            cnt_next      = cnt_reg - CNT_ONE;
            if (cnt_reg == '0) begin
               state_next = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Hold off new commands until the final word has left the pipe,
            // so bursts never overlap on the read port.
            if (rd_last_o) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- array
   // Each byte lane is its own array, so byte enables map onto independent
   // write strobes. The read port is registered, which gives the first cycle
   // of read latency. The contents are deliberately never reset.
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk_i) begin
         if (wr_en && wr_be_i[gi]) begin
            mem[addr_reg] <= wr_data_i[8*gi +: 8];
         end
         if (rd_issue) begin
            rd_byte_reg <= mem[addr_reg];
         end
      end

      assign mem_rd_data[8*gi +: 8] = rd_byte_reg;

`ifdef BURST_MEM_PARITY_EN
      logic par_mem [DEPTH];
      logic par_rd_reg;

      always_ff @(posedge clk_i) begin
         if (wr_en && wr_be_i[gi]) begin
            par_mem[addr_reg] <= even_parity(wr_data_i[8*gi +: 8]);
         end
         if (rd_issue) begin
            par_rd_reg <= par_mem[addr_reg];
         end
      end

      // A read has no byte enables, so every lane is checked.
      assign lane_perr[gi] = even_parity(rd_byte_reg) ^ par_rd_reg;
`else
      assign lane_perr[gi] = 1'b0;
`endif
   end

   // ---------------------------------------------------------------- read pipe
   mem_rd_pipe #(
      .DWIDTH (DWIDTH),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .issue_valid_i (rd_issue),
      .issue_last_i  (rd_issue_last),
      .mem_data_i    (mem_rd_data),
      .mem_perr_i    (|lane_perr),
      .rd_data_o     (rd_data_o),
      .rd_valid_o    (rd_valid_o),
      .rd_last_o     (rd_last_o),
      .rd_perr_o     (rd_perr_o),
      .busy_o        (pipe_busy)
   );

   assign busy_o = (state_reg != ST_IDLE) | pipe_busy;

endmodule

// File: tb/tb_burst_mem.sv
// -----------------------------------------------------------------------------
// tb_burst_mem
// Self-checking bench for burst_mem (16-word array, RD_LAT = 3). A word-level
// model of the array predicts every read word and the cycle it must appear in.
// A per-cycle compare process checks the read port against those predictions.
// Directed bursts pin the model with literal values. A randomized mix of write
// and read bursts follows.
// -----------------------------------------------------------------------------
module tb_burst_mem;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int LW = 4;
   localparam int RL = 3;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_wr;
   logic [AW-1:0]   cmd_addr;
   logic [LW-1:0]   cmd_len;
   logic            wr_valid;
   logic            wr_ready;
   logic [DW-1:0]   wr_data;
   logic [DW/8-1:0] wr_be;
   logic [DW-1:0]   rd_data;
   logic            rd_valid;
   logic            rd_last;
   logic            busy;
   logic            rd_perr;

   burst_mem #(
      .DWIDTH (DW),
      .AWIDTH (AW),
      .RD_LAT (RL),
      .LWIDTH (LW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_wr_i    (cmd_wr),
      .cmd_addr_i  (cmd_addr),
      .cmd_len_i   (cmd_len),
      .wr_valid_i  (wr_valid),
      .wr_ready_o  (wr_ready),
      .wr_data_i   (wr_data),
      .wr_be_i     (wr_be),
      .rd_data_o   (rd_data),
      .rd_valid_o  (rd_valid),
      .rd_last_o   (rd_last),
      .busy_o      (busy),
      .rd_perr_o   (rd_perr)
   );

   always #5 clk = ~clk;

   // Cycle index of the current clock period (bumped at every rising edge).
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        last;
      logic        perr;
   } rd_word_t;

   rd_word_t    exp_q[$];
   rd_word_t    obs_q[$];
   logic [31:0] mdl [DEPTH];
   logic [31:0] wdata [DEPTH];
   logic [3:0]  wbe [DEPTH];
   int          ready_at = 0;   // first cycle the DUT may accept a command
   int          flip_addr = -1; // word whose stored parity has been corrupted
   bit          chk_en = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Per-cycle read port check against the model's predictions.
   always @(negedge clk) begin
      if (!rst && chk_en) begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("rd_valid", rd_valid, 1);
            check("rd_data", rd_data, exp_q[0].data);
            check("rd_last", rd_last, exp_q[0].last);
            check("rd_perr", rd_perr, exp_q[0].perr);
            void'(exp_q.pop_front());
         end else begin
            check("rd_valid_idle", rd_valid, 0);
            check("rd_data_idle", rd_data, 0);
            check("rd_last_idle", rd_last, 0);
            check("rd_perr_idle", rd_perr, 0);
         end
         if (rd_valid) obs_q.push_back('{cyc, rd_data, rd_last, rd_perr});
      end
   end

   // Present a command and wait (bounded) for acceptance. It must be accepted
   // exactly when the previous burst has finished. Read bursts queue their
   // predicted words here.
   task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [3:0] l,
                           output int acc);
      int raise_cyc;
      int n;
      raise_cyc = cyc;
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_len   = l;
      acc = -1;
      n = 0;
      while (acc < 0 && n < 300) begin
         @(negedge clk);
         if (cmd_ready) acc = cyc;
         else n++;
      end
      if (acc < 0) begin
         check("cmd_accept_timeout", cmd_ready, 1);
      end else begin
         check("cmd_accept_cycle", acc, (raise_cyc > ready_at) ? raise_cyc : ready_at);
         if (!wr) begin
            for (int i = 0; i <= int'(l); i++) begin
               int idx;
               idx = (int'(a) + i) % DEPTH;
               exp_q.push_back('{acc + 1 + i + RL, mdl[idx], (i == int'(l)), (idx == flip_addr)});
            end
            ready_at = acc + 2 + int'(l) + RL;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_wr    = 1'($urandom);
      cmd_addr  = 4'($urandom);
      cmd_len   = 4'($urandom);
   endtask

   // Write burst from wdata/wbe with random wr_valid stalls. abort_at >= 0
   // pulses reset while that word is presented.
   task automatic do_write(input logic [3:0] a, input logic [3:0] l, input int abort_at);
      int acc;
      send_cmd(1'b1, a, l, acc);
      if (acc < 0) return;
      for (int i = 0; i <= int'(l); i++) begin
         int stalls;
         stalls = $urandom_range(0, 2);
         repeat (stalls) begin
            wr_valid = 1'b0;
            wr_data  = $urandom;
            @(negedge clk);
            check("wr_ready_stall", wr_ready, 1);
            @(posedge clk);
            #1;
         end
         wr_valid = 1'b1;
         wr_data  = wdata[i];
         wr_be    = wbe[i];
         if (i == abort_at) begin
            #2 rst = 1'b1;
            #1;
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_wr_ready", wr_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd_last", rd_last, 0);
            check("rst_rd_perr", rd_perr, 0);
            check("rst_rd_data", rd_data, 0);
            @(posedge clk);
            #2;
            rst = 1'b0;
            wr_valid = 1'b0;
            ready_at = cyc;
            return;
         end
         @(negedge clk);
         check("wr_ready", wr_ready, 1);
         check("busy_write", busy, 1);
         @(posedge clk);
         for (int b = 0; b < 4; b++) begin
            if (wbe[i][b]) mdl[(int'(a) + i) % DEPTH][8*b +: 8] = wdata[i][8*b +: 8];
         end
         #1;
      end
      wr_valid = 1'b0;
      wr_data  = $urandom;
      ready_at = cyc;
   endtask

   task automatic do_read(input logic [3:0] a, input logic [3:0] l, output int acc);
      send_cmd(1'b0, a, l, acc);
   endtask

   // Run until the DUT is due back in IDLE, driving wr_valid noise that must
   // never reach the array.
   task automatic wait_idle();
      while (cyc < ready_at) begin
         wr_valid = 1'($urandom);
         wr_data  = $urandom;
         wr_be    = 4'($urandom);
         @(posedge clk);
         #1;
      end
      wr_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "tb_burst_mem stopped by watchdog");
   end

   initial begin
      int acc;
      int acc2;
      logic [31:0] old8;
      logic [31:0] old9;

      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_wr = 1'b0;
      cmd_addr = '0;
      cmd_len = '0;
      wr_valid = 1'b0;
      wr_data = '0;
      wr_be = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_wr_ready", wr_ready, 0);
      check("reset_busy", busy, 0);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_data", rd_data, 0);
      rst = 1'b0;
      chk_en = 1'b1;
      ready_at = cyc;

      // Fill the whole array so every model word is known.
      for (int i = 0; i < DEPTH; i++) begin
         wdata[i] = $urandom;
         wbe[i] = 4'hF;
      end
      do_write(4'h0, 4'hF, -1);

      // Four-word write then read-back with latency check.
      for (int i = 0; i < 4; i++) begin
         wdata[i] = 32'hA0 + i;
         wbe[i] = 4'hF;
      end
      do_write(4'h4, 4'h3, -1);
      obs_q.delete();
      do_read(4'h4, 4'h3, acc);
      wait_idle();
      check("burst4_count", obs_q.size(), 4);
      if (obs_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("burst4_data", obs_q[i].data, 32'hA0 + i);
            check("burst4_last", obs_q[i].last, (i == 3));
         end
         check("burst4_latency", obs_q[0].cyc - acc, 4);
      end

      // Byte-enable merge.
      wdata[0] = 32'h11223344;
      wbe[0] = 4'hF;
      do_write(4'h9, 4'h0, -1);
      wdata[0] = 32'hFFFFFFFF;
      wbe[0] = 4'b0101;
      do_write(4'h9, 4'h0, -1);
      obs_q.delete();
      do_read(4'h9, 4'h0, acc);
      wait_idle();
      check("be_merge_count", obs_q.size(), 1);
      if (obs_q.size() == 1) check("be_merge_data", obs_q[0].data, 32'h11FF33FF);

      // Address wrap across the top of the array.
      for (int i = 0; i < 4; i++) begin
         wdata[i] = 32'hC0DE0000 + i;
         wbe[i] = 4'hF;
      end
      do_write(4'hE, 4'h3, -1);
      obs_q.delete();
      do_read(4'h0, 4'h0, acc);
      wait_idle();
      check("wrap_count", obs_q.size(), 1);
      if (obs_q.size() == 1) check("wrap_data", obs_q[0].data, 32'hC0DE0002);
      do_read(4'hF, 4'h2, acc);
      wait_idle();

      // Reset during the third word of a four-word write.
      old8 = mdl[8];
      old9 = mdl[9];
      for (int i = 0; i < 4; i++) begin
         wdata[i] = 32'hD0 + i;
         wbe[i] = 4'hF;
      end
      do_write(4'h6, 4'h3, 2);
      obs_q.delete();
      do_read(4'h6, 4'h3, acc);
      wait_idle();
      check("abort_count", obs_q.size(), 4);
      if (obs_q.size() == 4) begin
         check("abort_word0", obs_q[0].data, 32'hD0);
         check("abort_word1", obs_q[1].data, 32'hD1);
         check("abort_word2", obs_q[2].data, old8);
         check("abort_word3", obs_q[3].data, old9);
      end

      // Back-to-back reads: the second waits for the first burst to drain.
      do_read(4'h1, 4'h2, acc);
      do_read(4'h5, 4'h1, acc2);
      check("b2b_gap", acc2 - acc, 7);
      wait_idle();

      // Randomized burst mix.
      for (int t = 0; t < 40; t++) begin
         logic [3:0] a;
         logic [3:0] l;
         a = 4'($urandom);
         l = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < DEPTH; i++) begin
               wdata[i] = $urandom;
               wbe[i] = 4'($urandom);
            end
            do_write(a, l, -1);
            wait_idle();
         end else begin
            do_read(a, l, acc);
            if ($urandom_range(0, 1) == 1) wait_idle();
         end
      end
      wait_idle();

`ifdef BURST_MEM_PARITY_EN
      // Corrupt one stored parity bit; only that word may flag an error.
      flip_addr = 3;
      dut.g_lane[1].par_mem[3] = ~dut.g_lane[1].par_mem[3];
      obs_q.delete();
      do_read(4'h2, 4'h2, acc);
      wait_idle();
      check("perr_count", obs_q.size(), 3);
      if (obs_q.size() == 3) begin
         check("perr_word0", obs_q[0].perr, 0);
         check("perr_word1", obs_q[1].perr, 1);
         check("perr_word2", obs_q[2].perr, 0);
      end
      dut.g_lane[1].par_mem[3] = ~dut.g_lane[1].par_mem[3];
      flip_addr = -1;
`endif

      repeat (5) @(posedge clk);
      #1;
      check("end_queue_empty", exp_q.size(), 0);
      check("end_busy", busy, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/burst_mem.md
BURST_MEM -- requirements
Module: burst_mem

Interface
REQ-001 Parameter DWIDTH, default my_params_pkg::DWIDTH, data word width in bits; multiple of 8.
REQ-002 Parameter AWIDTH, default my_params_pkg::AWIDTH, word address width; depth 2**AWIDTH.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles, legal range 1..4.
REQ-004 Parameter LWIDTH, default 4, burst length field width; max burst 2**LWIDTH words.
REQ-005 clk_i  in  1  single clock; all logic on posedge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 cmd_valid_i  in  1  command request.
REQ-008 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-009 cmd_wr_i  in  1  1 = write burst, 0 = read burst.
REQ-010 cmd_addr_i  in  AWIDTH  burst start word address.
REQ-011 cmd_len_i  in  LWIDTH  burst length minus one.
REQ-012 wr_valid_i / wr_ready_o  in / out  1  write-data handshake.
REQ-013 wr_data_i  in  DWIDTH  write word; wr_be_i  in  DWIDTH/8  byte enables.
REQ-014 rd_data_o  out  DWIDTH  read word; zero when rd_valid_o low.
REQ-015 rd_valid_o, rd_last_o  out  1  read word valid; last word of burst.
REQ-016 busy_o  out  1  high whenever state is not IDLE or read pipeline non-empty.
REQ-017 rd_perr_o  out  1  parity error on current read word.

Function
REQ-018 FSM states IDLE, WRITE, READ, DRAIN; cmd_ready_o high only in IDLE.
REQ-019 IDLE->WRITE/READ on cmd_valid_i&cmd_ready_o; address and remaining count latched that cycle.
REQ-020 WRITE: wr_ready_o high; each wr_valid_i&wr_ready_o writes enabled bytes to current address, increments address, decrements count; disabled bytes unchanged.
REQ-021 WRITE->IDLE after the word with count zero is accepted; wr_valid_i stalls hold state indefinitely.
REQ-022 READ: one array read per cycle, no stalls; READ->DRAIN after issuing count-zero word.
REQ-023 Each read word appears on rd_data_o with rd_valid_o exactly RD_LAT cycles after issue; rd_last_o marks the final word.
REQ-024 DRAIN->IDLE in the cycle rd_last_o is asserted; next command accepted the following cycle.
REQ-025 Address increment wraps modulo 2**AWIDTH (0x..FF -> 0); burst continues across wrap.
REQ-026 cmd_len_i = 0 is a single-word burst; max length 2**LWIDTH words.
REQ-027 wr_valid_i outside WRITE is ignored; no array write.

Reset
REQ-028 On rst_i: state IDLE, cmd_ready_o 1, wr_ready_o 0, rd_valid_o/rd_last_o/rd_perr_o/busy_o 0, rd_data_o 0, read pipeline flushed.
REQ-029 Reset mid-burst aborts the burst; already-written words persist; array contents never reset.

Configuration
REQ-030 Macro BURST_MEM_PARITY_EN defined: one even-parity bit per byte stored on write, checked on read; rd_perr_o high with rd_valid_o if any enabled byte mismatches.
REQ-031 Macro undefined: no parity storage; rd_perr_o constant 0.

Structure
REQ-032 DWIDTH, AWIDTH defaults and the FSM state typedef live in my_params_pkg.
REQ-033 Read latency delay line (data, valid, last, perr) is sub-module mem_rd_pipe, parametrised by RD_LAT.

Verification
REQ-034 Write len=3 at 0x10 data 0xA0..0xA3, then read len=3 at 0x10 -> four words 0xA0..0xA3, rd_last_o on 4th, first word RD_LAT cycles after issue.
REQ-035 Write 0x11223344 be=1111 then 0xFFFFFFFF be=0101 to same addr, read -> 0x11FF33FF.
REQ-036 AWIDTH=4, write len=3 at 0xE -> addresses 0xE,0xF,0x0,0x1 written; read at 0x0 returns 3rd word.
REQ-037 rst_i pulsed during word 2 of a 4-word write -> outputs reset values, words 0-1 retained, word 2 address unchanged.
REQ-038 RD_LAT=3, back-to-back read commands -> second cmd_ready_o only after first rd_last_o; no overlap.
REQ-039 BURST_MEM_PARITY_EN, force one stored parity bit flipped -> rd_perr_o high on that word only.
